action_cfg_loader: RTL and testbench
====================================

ACTION_CFG_LOADER -- requirements
Module: action_cfg_loader

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 1024, maximum idle cycles allowed between bytes inside a frame.
REQ-002 clk  in  1  sole clock; all logic on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 cfg_valid_i  in  1  config byte present.
REQ-005 cfg_data_i  in  `BYTE_BUS  config byte.
REQ-006 cfg_last_i  in  1  marks final byte of frame.
REQ-007 cfg_ready_o  out  1  loader accepts a byte this cycle; transfer = valid & ready.
REQ-008 exec_busy_i  in  1  executor not in its free state; commit is deferred while high.
REQ-009 mod_start_o  out  1  one-cycle commit strobe to executor mod_start_i.
REQ-010 mod_hit_action_addr_o, mod_miss_action_addr_o  out  `ADDR_BUS  committed entry addresses.
REQ-011 mod_ops_o  out  `QUAD_BUS x `MAX_OP_NUM  committed op table, index 0 first.
REQ-012 err_o  out  1  one-cycle pulse on frame rejection.
REQ-013 commit_cnt_o  out  16  count of successful commits, wraps at 0xFFFF -> 0.

Function
REQ-014 Frame byte order: hit addr, miss addr, op count N, then N ops of 8 bytes each, big-endian (first byte -> bits 63:56); last byte carries cfg_last_i.
REQ-015 Address bytes are zero-extended to `ADDR_BUS.
REQ-016 States: IDLE, HIT, MISS, CNT, OPS, WAIT_EXEC, COMMIT, DRAIN; IDLE->HIT on first accepted byte, sequential advance per accepted byte.
REQ-017 Bytes assemble into a staging table; staging entries with index >= N are zero (NOP) at commit.
REQ-018 N = 0 is legal: frame ends at CNT byte; committed table is all zeros.
REQ-019 Rejection (-> DRAIN if cfg_last_i not yet seen, else IDLE; err_o pulse): hit or miss addr >= `MAX_OP_NUM; N > `MAX_OP_NUM; cfg_last_i before expected final byte; cfg_last_i absent on expected final byte.
REQ-020 DRAIN: cfg_ready_o high, bytes discarded until cfg_last_i accepted, then IDLE.
REQ-021 Timeout: in HIT..OPS, TIMEOUT_CYCLES consecutive cycles without a transfer -> err_o pulse, IDLE; counter resets on every transfer.
REQ-022 cfg_ready_o high in IDLE..OPS and DRAIN; low in WAIT_EXEC and COMMIT.
REQ-023 After a valid final byte -> WAIT_EXEC; stays while exec_busy_i high; when low -> COMMIT.
REQ-024 COMMIT (one cycle): staging copied to mod_* outputs, mod_start_o high, commit_cnt_o increments, next state IDLE.
REQ-025 mod_* outputs change only in COMMIT and hold between commits; rejected frames never alter them.
REQ-026 Latency: mod_start_o asserts 2 cycles after final byte transfer when exec_busy_i low.
REQ-027 Simultaneous error conditions produce exactly one err_o pulse.

Reset
REQ-028 rst high: state IDLE, staging and mod_ops_o all zero, addresses zero, mod_start_o, err_o, commit_cnt_o zero, timeout counter zero, cfg_ready_o low during reset cycle.
REQ-029 Reset mid-frame or in WAIT_EXEC abandons the frame with no mod_start_o and no err_o.

Structure
REQ-030 `MAX_OP_NUM, `QUAD_BUS, `ADDR_BUS, `BYTE_BUS, `TRUE/`FALSE come from the shared def.svh; frame field offsets (3-byte header, 8 bytes per op) are defined there.
REQ-031 State enum is local; single module, no sub-module.

Verification
REQ-032 Frame 00 02 02 + op0 0x0400_0000_0000_0000 + op1 zeros, exec_busy_i low -> mod_start_o one cycle, hit 0, miss 2, mod_ops_o[0]=0x0400000000000000, rest 0, commit_cnt_o=1.
REQ-033 Same frame with exec_busy_i high 20 cycles after final byte -> cfg_ready_o low, mod_start_o exactly 1 cycle after exec_busy_i falls.
REQ-034 Count byte `MAX_OP_NUM+1 -> err_o pulse, bytes drained to cfg_last_i, outputs unchanged, commit_cnt_o unchanged.
REQ-035 cfg_last_i on 5th byte of a N=1 frame -> err_o, IDLE; next valid frame commits normally.
REQ-036 Stall TIMEOUT_CYCLES after 2 bytes -> err_o on that cycle, IDLE; rst asserted mid-OPS -> no strobe, no err_o, all outputs zero.

Source files
------------

// File: rtl/action_cfg_loader_pkg.sv
// ============================================================================
// Module      : action_cfg_loader_pkg
// Description : Shared widths, frame layout constants and types for the
//               action configuration loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package action_cfg_loader_pkg;

  // Bus widths and table depth (MAX_OP_NUM must be a power of two)
  localparam int unsigned MAX_OP_NUM = 8;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned QUAD_W     = 64;

  // Frame layout: hit addr, miss addr, op count, then 8 bytes per op
  localparam int unsigned HDR_BYTES  = 3;
  localparam int unsigned OP_BYTES   = 8;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Derived widths
  localparam int unsigned CNT_W     = $clog2(MAX_OP_NUM + 1);
  localparam int unsigned OPIDX_W   = $clog2(MAX_OP_NUM);
  localparam int unsigned OPB_SHIFT = $clog2(OP_BYTES);
  localparam int unsigned BCNT_W    = OPIDX_W + OPB_SHIFT;
  localparam int unsigned TOT_W     = BCNT_W + 1;

  typedef logic [BYTE_W-1:0] byte_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [QUAD_W-1:0] quad_t;

  // Index of the last op byte of a frame carrying n ops (n >= 1)
  function automatic logic [TOT_W-1:0] last_op_byte(input logic [CNT_W-1:0] n);
    logic [TOT_W-1:0] total;
    total = TOT_W'(n) << OPB_SHIFT;
    return total - TOT_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/action_cfg_loader.sv
// ============================================================================
// Module      : action_cfg_loader
// Description : Receives a byte-serial action configuration frame, validates
//               it, stages the op table and commits it to the executor with
//               a one-cycle start strobe once the executor is free.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module action_cfg_loader
  import action_cfg_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cfg_valid_i,
  input  logic [BYTE_W-1:0]                cfg_data_i,
  input  logic                             cfg_last_i,
  output logic                             cfg_ready_o,
  input  logic                             exec_busy_i,
  output logic                             mod_start_o,
  output logic [ADDR_W-1:0]                mod_hit_action_addr_o,
  output logic [ADDR_W-1:0]                mod_miss_action_addr_o,
  output logic [MAX_OP_NUM-1:0][QUAD_W-1:0] mod_ops_o,
  output logic                             err_o,
  output logic [15:0]                      commit_cnt_o
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  // HIT/MISS/CNT name the field most recently received; CNT expects the
  // first op byte, OPS the remaining ones.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_HIT       = 3'd1,
    S_MISS      = 3'd2,
    S_CNT       = 3'd3,
    S_OPS       = 3'd4,
    S_WAIT_EXEC = 3'd5,
    S_COMMIT    = 3'd6,
    S_DRAIN     = 3'd7
  } state_e;

  state_e                           state_q, state_d;
  logic                             err_q, err_d;
  logic                             start_q, start_d;
  addr_t                            hit_q, hit_d;
  addr_t                            miss_q, miss_d;
  addr_t                            mhit_q, mhit_d;
  addr_t                            mmiss_q, mmiss_d;
  logic [CNT_W-1:0]                 n_q, n_d;
  logic [BCNT_W-1:0]                bcnt_q, bcnt_d;
  logic [TMO_W-1:0]                 tmo_q, tmo_d;
  logic [MAX_OP_NUM-1:0][QUAD_W-1:0] stage_q, stage_d;
  logic [MAX_OP_NUM-1:0][QUAD_W-1:0] ops_q, ops_d;
  logic [15:0]                      cc_q, cc_d;

  logic                             xfer;
  logic                             in_frame;
  logic                             timeout;
  logic                             final_op_byte;
  logic                             reject;
  logic [OPIDX_W-1:0]               op_idx;

  assign xfer          = cfg_valid_i & cfg_ready_o;
  assign in_frame      = (state_q == S_HIT) || (state_q == S_MISS) ||
                         (state_q == S_CNT) || (state_q == S_OPS);
  assign timeout       = in_frame && !xfer &&
                         (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign final_op_byte = ({1'b0, bcnt_q} == last_op_byte(n_q));
  assign op_idx        = bcnt_q[BCNT_W-1:OPB_SHIFT];

  assign mod_start_o            = start_q;
  assign err_o                  = err_q;
  assign mod_hit_action_addr_o  = mhit_q;
  assign mod_miss_action_addr_o = mmiss_q;
  assign mod_ops_o              = ops_q;
  assign commit_cnt_o           = cc_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, frame validation and the single error/commit decision
  always_comb begin
    state_d = state_q;
    err_d   = FALSE;
    start_d = FALSE;
    reject  = FALSE;
    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          if ((cfg_data_i >= BYTE_W'(MAX_OP_NUM)) || cfg_last_i) reject = TRUE;
          else state_d = S_HIT;
        end
      end
      S_HIT: begin
        if (xfer) begin
          if ((cfg_data_i >= BYTE_W'(MAX_OP_NUM)) || cfg_last_i) reject = TRUE;
          else state_d = S_MISS;
        end
      end
      S_MISS: begin
        if (xfer) begin
          if (cfg_data_i > BYTE_W'(MAX_OP_NUM)) begin
            reject = TRUE;
          end else if (cfg_data_i == '0) begin
            // Empty op list: the count byte is the final byte
            if (cfg_last_i) state_d = S_WAIT_EXEC;
            else reject = TRUE;
          end else if (cfg_last_i) begin
            reject = TRUE;
          end else begin
            state_d = S_CNT;
          end
        end
      end
      S_CNT, S_OPS: begin
        if (xfer) begin
          if (final_op_byte != cfg_last_i) reject = TRUE;
          else if (final_op_byte) state_d = S_WAIT_EXEC;
          else state_d = S_OPS;
        end
      end
      S_WAIT_EXEC: begin
        if (!exec_busy_i) begin
          state_d = S_COMMIT;
          start_d = TRUE;
        end
      end
      S_COMMIT: state_d = S_IDLE;
      S_DRAIN: begin
        if (xfer && cfg_last_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Reject and timeout are exclusive (timeout needs an idle cycle), so
    // at most one err pulse is raised per frame.
    if (reject) begin
      err_d   = TRUE;
      state_d = cfg_last_i ? S_IDLE : S_DRAIN;
    end else if (timeout) begin
      err_d   = TRUE;
      state_d = S_IDLE;
    end
  end

  // Handshake output: accept bytes while receiving or draining, never in reset
  always_comb begin
    cfg_ready_o = FALSE;
    if (!rst) begin
      case (state_q)
        S_IDLE, S_HIT, S_MISS, S_CNT, S_OPS, S_DRAIN: cfg_ready_o = TRUE;
        default:                                      cfg_ready_o = FALSE;
      endcase
    end
  end

  // Staging assembly, idle-gap counter and commit copy
  always_comb begin
    hit_d   = hit_q;
    miss_d  = miss_q;
    n_d     = n_q;
    bcnt_d  = bcnt_q;
    stage_d = stage_q;
    mhit_d  = mhit_q;
    mmiss_d = mmiss_q;
    ops_d   = ops_q;
    cc_d    = cc_q;
    tmo_d   = '0;
    if (in_frame && !xfer && !timeout) tmo_d = tmo_q + TMO_W'(1);
    if (xfer) begin
      case (state_q)
        S_IDLE: begin
          hit_d   = ADDR_W'(cfg_data_i);
          stage_d = '0;
        end
        S_HIT: miss_d = ADDR_W'(cfg_data_i);
        S_MISS: begin
          n_d    = CNT_W'(cfg_data_i);
          bcnt_d = '0;
        end
        S_CNT, S_OPS: begin
          // Big-endian: earlier bytes shift toward the top of the quad
          stage_d[op_idx] = {stage_q[op_idx][QUAD_W-BYTE_W-1:0], cfg_data_i};
          bcnt_d          = bcnt_q + BCNT_W'(1);
        end
        default: ;
      endcase
    end
    if (start_d) begin
      mhit_d  = hit_q;
      mmiss_d = miss_q;
      for (int i = 0; i < MAX_OP_NUM; i++) begin
        ops_d[i] = (CNT_W'(i) < n_q) ? stage_q[i] : '0;
      end
      cc_d = cc_q + 16'd1;
    end
  end

  // Datapath and registered output flops
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q   <= FALSE;
      start_q <= FALSE;
      hit_q   <= '0;
      miss_q  <= '0;
      n_q     <= '0;
      bcnt_q  <= '0;
      tmo_q   <= '0;
      stage_q <= '0;
      mhit_q  <= '0;
      mmiss_q <= '0;
      ops_q   <= '0;
      cc_q    <= '0;
    end else begin
      err_q   <= err_d;
      start_q <= start_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      n_q     <= n_d;
      bcnt_q  <= bcnt_d;
      tmo_q   <= tmo_d;
      stage_q <= stage_d;
      mhit_q  <= mhit_d;
      mmiss_q <= mmiss_d;
      ops_q   <= ops_d;
      cc_q    <= cc_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_action_cfg_loader.sv
// ============================================================================
// Module      : tb_action_cfg_loader
// Description : Self-checking bench for action_cfg_loader: a table of frames
//               with hand-computed results plus latency, back-pressure,
//               timeout and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_action_cfg_loader;
  import action_cfg_loader_pkg::*;

  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst;
  logic cfg_valid_i;
  logic [BYTE_W-1:0] cfg_data_i;
  logic cfg_last_i;
  logic cfg_ready_o;
  logic exec_busy_i;
  logic mod_start_o;
  logic [ADDR_W-1:0] mod_hit_action_addr_o;
  logic [ADDR_W-1:0] mod_miss_action_addr_o;
  logic [MAX_OP_NUM-1:0][QUAD_W-1:0] mod_ops_o;
  logic err_o;
  logic [15:0] commit_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;
  int err_total = 0;
  int start_total = 0;

  always #5 clk = ~clk;

  action_cfg_loader #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .cfg_valid_i            (cfg_valid_i),
    .cfg_data_i             (cfg_data_i),
    .cfg_last_i             (cfg_last_i),
    .cfg_ready_o            (cfg_ready_o),
    .exec_busy_i            (exec_busy_i),
    .mod_start_o            (mod_start_o),
    .mod_hit_action_addr_o  (mod_hit_action_addr_o),
    .mod_miss_action_addr_o (mod_miss_action_addr_o),
    .mod_ops_o              (mod_ops_o),
    .err_o                  (err_o),
    .commit_cnt_o           (commit_cnt_o)
  );

  // Pulse counters sampled away from the active edge
  always @(negedge clk) begin
    if (err_o)       err_total++;
    if (mod_start_o) start_total++;
  end

  typedef struct {
    string nm;
    byte_t hit;
    byte_t miss;
    byte_t cnt;
    quad_t op0;
    quad_t op1;
    int    last_at;
    int    e_start;
    int    e_err;
    byte_t e_hit;
    byte_t e_miss;
    quad_t e_op0;
    quad_t e_op1;
    quad_t e_rest;
    int    e_cc;
  } vec_t;

  vec_t vt [0:13];

  function automatic vec_t mkv(input string nm, input byte_t hit, input byte_t miss,
                               input byte_t cnt, input quad_t op0, input quad_t op1,
                               input int last_at, input int e_start, input int e_err,
                               input byte_t e_hit, input byte_t e_miss, input quad_t e_op0,
                               input quad_t e_op1, input quad_t e_rest, input int e_cc);
    vec_t v;
    v.nm = nm; v.hit = hit; v.miss = miss; v.cnt = cnt; v.op0 = op0; v.op1 = op1;
    v.last_at = last_at; v.e_start = e_start; v.e_err = e_err; v.e_hit = e_hit;
    v.e_miss = e_miss; v.e_op0 = e_op0; v.e_op1 = e_op1; v.e_rest = e_rest; v.e_cc = e_cc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_ops(input string nm, input logic [MAX_OP_NUM-1:0][QUAD_W-1:0] exp);
    n_tests++;
    if (mod_ops_o !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, mod_ops_o, exp);
    end
  endtask

  // Byte k of the frame described by v (ops beyond op1 are filled with AA)
  function automatic byte_t frame_byte(input vec_t v, input int k);
    quad_t t;
    if (k == 0) return v.hit;
    if (k == 1) return v.miss;
    if (k == 2) return v.cnt;
    if (k <= 10) begin
      t = v.op0 >> (8 * (10 - k));
      return t[7:0];
    end
    if (k <= 18) begin
      t = v.op1 >> (8 * (18 - k));
      return t[7:0];
    end
    return 8'hAA;
  endfunction

  task automatic send_byte(input byte_t b, input logic l);
    int tries;
    tries = 0;
    cfg_valid_i = 1'b1;
    cfg_data_i  = b;
    cfg_last_i  = l;
    @(negedge clk);
    while (!cfg_ready_o && tries < 50) begin
      @(negedge clk);
      tries++;
    end
    if (!cfg_ready_o) begin
      n_tests++;
      n_fail++;
      $display("FAIL ready_wait: cfg_ready_o stayed 0 for %0d cycles, expected 1", tries);
    end
    @(posedge clk); #1;
    cfg_valid_i = 1'b0;
    cfg_last_i  = 1'b0;
  endtask

  task automatic send_frame(input vec_t v);
    for (int k = 0; k <= v.last_at; k++) send_byte(frame_byte(v, k), k == v.last_at);
  endtask

  task automatic run_vec(input vec_t v);
    int e0, s0;
    logic [MAX_OP_NUM-1:0][QUAD_W-1:0] eo;
    e0 = err_total;
    s0 = start_total;
    send_frame(v);
    repeat (6) @(posedge clk);
    #1;
    for (int i = 0; i < MAX_OP_NUM; i++)
      eo[i] = (i == 0) ? v.e_op0 : ((i == 1) ? v.e_op1 : v.e_rest);
    chk({v.nm, "/start"}, 64'(start_total - s0), 64'(v.e_start));
    chk({v.nm, "/err"},   64'(err_total - e0),   64'(v.e_err));
    chk({v.nm, "/hit"},   64'(mod_hit_action_addr_o),  64'(v.e_hit));
    chk({v.nm, "/miss"},  64'(mod_miss_action_addr_o), 64'(v.e_miss));
    chk({v.nm, "/cnt"},   64'(commit_cnt_o), 64'(v.e_cc));
    chk_ops({v.nm, "/ops"}, eo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int e0, s0;
    //            name        hit    miss   cnt    op0                     op1                     last st er e_hit  e_miss e_op0                   e_op1                   e_rest                  cc
    vt[0]  = mkv("basic",     8'h00, 8'h02, 8'h02, 64'h0400000000000000, 64'h0,                 18, 1, 0, 8'h00, 8'h02, 64'h0400000000000000, 64'h0,                 64'h0,                 1);
    vt[1]  = mkv("two_ops",   8'h07, 8'h03, 8'h02, 64'h0102030405060708, 64'h1122334455667788, 18, 1, 0, 8'h07, 8'h03, 64'h0102030405060708, 64'h1122334455667788, 64'h0,                 2);
    vt[2]  = mkv("one_op",    8'h01, 8'h05, 8'h01, 64'hDEADBEEFCAFEF00D, 64'h9999999999999999, 10, 1, 0, 8'h01, 8'h05, 64'hDEADBEEFCAFEF00D, 64'h0,                 64'h0,                 3);
    vt[3]  = mkv("n_zero",    8'h04, 8'h06, 8'h00, 64'h0,                 64'h0,                  2, 1, 0, 8'h04, 8'h06, 64'h0,                 64'h0,                 64'h0,                 4);
    vt[4]  = mkv("cnt_9",     8'h01, 8'h01, 8'h09, 64'h5555555555555555, 64'h0,                 12, 0, 1, 8'h04, 8'h06, 64'h0,                 64'h0,                 64'h0,                 4);
    vt[5]  = mkv("hit_8",     8'h08, 8'h00, 8'h01, 64'h1111111111111111, 64'h0,                  5, 0, 1, 8'h04, 8'h06, 64'h0,                 64'h0,                 64'h0,                 4);
    vt[6]  = mkv("early_lst", 8'h01, 8'h02, 8'h01, 64'h7777777777777777, 64'h0,                  4, 0, 1, 8'h04, 8'h06, 64'h0,                 64'h0,                 64'h0,                 4);
    vt[7]  = mkv("no_last",   8'h01, 8'h02, 8'h01, 64'h2222222222222222, 64'h3333333333333333, 13, 0, 1, 8'h04, 8'h06, 64'h0,                 64'h0,                 64'h0,                 4);
    vt[8]  = mkv("n0_nolast", 8'h01, 8'h02, 8'h00, 64'h4444444444444444, 64'h0,                  4, 0, 1, 8'h04, 8'h06, 64'h0,                 64'h0,                 64'h0,                 4);
    vt[9]  = mkv("lst_first", 8'h01, 8'h02, 8'h01, 64'h0,                 64'h0,                  0, 0, 1, 8'h04, 8'h06, 64'h0,                 64'h0,                 64'h0,                 4);
    vt[10] = mkv("dbl_err",   8'h09, 8'h02, 8'h01, 64'h0,                 64'h0,                  0, 0, 1, 8'h04, 8'h06, 64'h0,                 64'h0,                 64'h0,                 4);
    vt[11] = mkv("miss_8",    8'h00, 8'h08, 8'h01, 64'h0,                 64'h0,                  5, 0, 1, 8'h04, 8'h06, 64'h0,                 64'h0,                 64'h0,                 4);
    vt[12] = mkv("recover",   8'h02, 8'h00, 8'h01, 64'h0000000000000001, 64'h0,                 10, 1, 0, 8'h02, 8'h00, 64'h0000000000000001, 64'h0,                 64'h0,                 5);
    vt[13] = mkv("n_max",     8'h07, 8'h07, 8'h08, 64'hA1A2A3A4A5A6A7A8, 64'hB1B2B3B4B5B6B7B8, HDR_BYTES + 8*OP_BYTES - 1,
                                                                                                        1, 0, 8'h07, 8'h07, 64'hA1A2A3A4A5A6A7A8, 64'hB1B2B3B4B5B6B7B8, 64'hAAAAAAAAAAAAAAAA, 6);

    // Reset state
    rst = 1'b1; cfg_valid_i = 1'b0; cfg_data_i = '0; cfg_last_i = 1'b0; exec_busy_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst/ready", 64'(cfg_ready_o), 64'd0);
    chk("rst/start", 64'(mod_start_o), 64'd0);
    chk("rst/err",   64'(err_o), 64'd0);
    chk("rst/cnt",   64'(commit_cnt_o), 64'd0);
    chk("rst/hit",   64'(mod_hit_action_addr_o), 64'd0);
    chk_ops("rst/ops", '0);
    rst = 1'b0;
    #1;
    chk("idle/ready", 64'(cfg_ready_o), 64'd1);

    for (int i = 0; i < 14; i++) run_vec(vt[i]);

    // Commit latency: strobe two cycles after the final byte transfer
    v = mkv("lat", 8'h03, 8'h04, 8'h01, 64'h0A0B0C0D0E0F1011, 64'h0, 10, 1, 0, 8'h03, 8'h04, 64'h0A0B0C0D0E0F1011, 64'h0, 64'h0, 7);
    send_frame(v);
    chk("lat/start_k1", 64'(mod_start_o), 64'd0);
    chk("lat/ready_wait", 64'(cfg_ready_o), 64'd0);
    @(posedge clk); #1;
    chk("lat/start_k2", 64'(mod_start_o), 64'd1);
    chk("lat/hit_k2",   64'(mod_hit_action_addr_o), 64'h03);
    chk("lat/op0_k2",   64'(mod_ops_o[0]), 64'h0A0B0C0D0E0F1011);
    chk("lat/ready_commit", 64'(cfg_ready_o), 64'd0);
    @(posedge clk); #1;
    chk("lat/start_k3", 64'(mod_start_o), 64'd0);
    chk("lat/cnt",      64'(commit_cnt_o), 64'd7);

    // Executor busy defers the commit
    v = mkv("busy", 8'h05, 8'h06, 8'h01, 64'h5555555555555555, 64'h0, 10, 1, 0, 8'h05, 8'h06, 64'h0, 64'h0, 64'h0, 8);
    for (int k = 0; k < 10; k++) send_byte(frame_byte(v, k), 1'b0);
    exec_busy_i = 1'b1;
    send_byte(frame_byte(v, 10), 1'b1);
    for (int i = 0; i < 20; i++) begin
      chk("busy/ready_low", 64'(cfg_ready_o), 64'd0);
      chk("busy/no_start",  64'(mod_start_o), 64'd0);
      @(posedge clk); #1;
    end
    chk("busy/hit_held", 64'(mod_hit_action_addr_o), 64'h03);
    exec_busy_i = 1'b0;
    @(posedge clk); #1;
    chk("busy/start", 64'(mod_start_o), 64'd1);
    chk("busy/ready_commit", 64'(cfg_ready_o), 64'd0);
    @(posedge clk); #1;
    chk("busy/start_off", 64'(mod_start_o), 64'd0);
    chk("busy/ready_idle", 64'(cfg_ready_o), 64'd1);
    chk("busy/cnt", 64'(commit_cnt_o), 64'd8);
    chk("busy/hit", 64'(mod_hit_action_addr_o), 64'h05);
    chk("busy/op0", 64'(mod_ops_o[0]), 64'h5555555555555555);

    // Timeout after two bytes
    e0 = err_total;
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    for (int i = 1; i <= TMO; i++) begin
      @(posedge clk); #1;
      if (i >= TMO - 1) chk("tmo/err_edge", 64'(err_o), (i == TMO) ? 64'd1 : 64'd0);
    end
    @(posedge clk); #1;
    chk("tmo/err_once", 64'(err_total - e0), 64'd1);
    chk("tmo/ready_idle", 64'(cfg_ready_o), 64'd1);
    chk("tmo/cnt_held", 64'(commit_cnt_o), 64'd8);
    run_vec(mkv("after_tmo", 8'h00, 8'h01, 8'h00, 64'h0, 64'h0, 2, 1, 0, 8'h00, 8'h01, 64'h0, 64'h0, 64'h0, 9));

    // Reset in the middle of the op bytes
    e0 = err_total;
    s0 = start_total;
    v = mkv("rst_ops", 8'h00, 8'h01, 8'h01, 64'h1234567812345678, 64'h0, 10, 0, 0, 8'h00, 8'h00, 64'h0, 64'h0, 64'h0, 0);
    for (int k = 0; k < 5; k++) send_byte(frame_byte(v, k), 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_ops/ready", 64'(cfg_ready_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_ops/start", 64'(start_total - s0), 64'd0);
    chk("rst_ops/err",   64'(err_total - e0), 64'd0);
    chk("rst_ops/cnt",   64'(commit_cnt_o), 64'd0);
    chk("rst_ops/miss",  64'(mod_miss_action_addr_o), 64'd0);
    chk_ops("rst_ops/ops", '0);

    // Reset while waiting for the executor
    v = mkv("rst_wait", 8'h03, 8'h03, 8'h00, 64'h0, 64'h0, 2, 0, 0, 8'h00, 8'h00, 64'h0, 64'h0, 64'h0, 0);
    exec_busy_i = 1'b1;
    send_frame(v);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exec_busy_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_wait/start", 64'(start_total - s0), 64'd0);
    chk("rst_wait/err",   64'(err_total - e0), 64'd0);
    chk("rst_wait/cnt",   64'(commit_cnt_o), 64'd0);
    chk("rst_wait/hit",   64'(mod_hit_action_addr_o), 64'd0);
    run_vec(mkv("post_rst", 8'h06, 8'h01, 8'h01, 64'hFEDCBA9876543210, 64'h0, 10, 1, 0, 8'h06, 8'h01, 64'hFEDCBA9876543210, 64'h0, 64'h0, 1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
